// File: rtl/gray_seq_pkg.sv
// ============================================================================
// gray_seq_pkg : code constants, code-to-index map and FSM encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package gray_seq_pkg;

   localparam logic [2:0] C_CODE_0 = 3'b000;
   localparam logic [2:0] C_CODE_1 = 3'b100;
   localparam logic [2:0] C_CODE_2 = 3'b110;
   localparam logic [2:0] C_CODE_3 = 3'b111;
   localparam logic [2:0] C_CODE_4 = 3'b101;
   localparam logic [2:0] C_CODE_5 = 3'b001;
   localparam logic [2:0] C_CODE_6 = 3'b011;
   localparam logic [2:0] C_CODE_7 = 3'b010;

   localparam logic [1:0] ST_ACQUIRE = 2'd0;
   localparam logic [1:0] ST_TRACK   = 2'd1;
   localparam logic [1:0] ST_FAULT   = 2'd2;

   function automatic logic [2:0] gray_to_idx(input logic [2:0] code);
      logic [2:0] idx;
      case (code)
         C_CODE_0: idx = 3'd0;
         C_CODE_1: idx = 3'd1;
         C_CODE_2: idx = 3'd2;
         C_CODE_3: idx = 3'd3;
         C_CODE_4: idx = 3'd4;
         C_CODE_5: idx = 3'd5;
         C_CODE_6: idx = 3'd6;
         default:  idx = 3'd7;
      endcase
      return idx;
   endfunction

endpackage

`default_nettype wire

// File: rtl/gray_in_filter.sv
// ============================================================================
// gray_in_filter : 2-flop synchronizer plus stability filter with accept strobe
// Rev 1.0
// ============================================================================
`default_nettype none

module gray_in_filter #(
   parameter int STABLE_CYC = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] gray_in,
   output logic [2:0] code,
   output logic       code_ok,
   output logic       new_code
);
   import gray_seq_pkg::*;

   localparam logic [3:0] C_STABLE   = 4'(STABLE_CYC);
   localparam logic [3:0] C_STABLE_M = 4'(STABLE_CYC - 1);

   logic [2:0] sync1_q, sync2_q, cand_q, filt_q;
   logic [2:0] cand_d, filt_d;
   logic [3:0] cnt_q, cnt_d;
   logic       vld_q, vld_d, new_q, new_d;
   logic       w_same, w_reach;

   always_comb begin
      w_same = (sync2_q == cand_q);
      cand_d = sync2_q;
      if (!w_same)
         cnt_d = 4'd1;
      else if (cnt_q >= C_STABLE)
         cnt_d = cnt_q;
      else
         cnt_d = cnt_q + 4'd1;
      // Strobe only on the edge the count reaches the threshold, not while it sits there
      w_reach = (cnt_d == C_STABLE) && !(w_same && (cnt_q == C_STABLE));
      new_d   = w_reach && !new_q;
      // Back-to-back acceptances are deferred one cycle by retrying the final count
      if (w_reach && new_q)
         cnt_d = C_STABLE_M;
      filt_d = new_d ? sync2_q : filt_q;
      vld_d  = vld_q | new_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 3'b000;
         sync2_q <= 3'b000;
         cand_q  <= 3'b000;
         cnt_q   <= 4'd0;
         filt_q  <= 3'b000;
         vld_q   <= 1'b0;
         new_q   <= 1'b0;
      end else begin
         sync1_q <= gray_in;
         sync2_q <= sync1_q;
         cand_q  <= cand_d;
         cnt_q   <= cnt_d;
         filt_q  <= filt_d;
         vld_q   <= vld_d;
         new_q   <= new_d;
      end
   end

   assign code     = filt_d;
   assign code_ok  = vld_d;
   assign new_code = new_d;

endmodule

`default_nettype wire

// File: rtl/gray_seq_decoder.sv
// ============================================================================
// gray_seq_decoder : tracks a 3-bit Gray sequence into a signed step count
// Rev 1.0
// ============================================================================
`default_nettype none

module gray_seq_decoder #(
   parameter int POS_W      = 8,
   parameter int STABLE_CYC = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [2:0]              gray_in,
   input  logic                    clr_pos,
   input  logic                    clr_err,
   output logic signed [POS_W-1:0] pos,
   output logic [2:0]              idx,
   output logic                    dir,
   output logic                    step_valid,
   output logic                    locked,
   output logic                    err
);
   import gray_seq_pkg::*;

   localparam logic [POS_W-1:0] C_ONE = POS_W'(1);

   logic [2:0]       w_code, w_idx, w_delta;
   logic             w_code_ok, w_new;
   logic [1:0]       state_q, state_d;
   logic [POS_W-1:0] pos_q, pos_d;
   logic [2:0]       idx_q, idx_d;
   logic             dir_q, dir_d, sv_q, sv_d;

   gray_in_filter #(.STABLE_CYC(STABLE_CYC)) u_filter (
      .clk      (clk),
      .rst      (rst),
      .gray_in  (gray_in),
      .code     (w_code),
      .code_ok  (w_code_ok),
      .new_code (w_new)
   );

   always_comb begin
      w_idx   = gray_to_idx(w_code);
      w_delta = w_idx - idx_q;
      state_d = state_q;
      pos_d   = pos_q;
      idx_d   = idx_q;
      dir_d   = dir_q;
      sv_d    = 1'b0;
      case (state_q)
         // A held code is taken as well, so re-acquire after FAULT needs no new edge
         ST_ACQUIRE: begin
            if (w_code_ok) begin
               idx_d   = w_idx;
               state_d = ST_TRACK;
            end
         end
         ST_TRACK: begin
            if (w_new) begin
               if (w_delta == 3'd1) begin
                  pos_d = pos_q + C_ONE;
                  dir_d = 1'b0;
                  sv_d  = 1'b1;
                  idx_d = w_idx;
               end else if (w_delta == 3'd7) begin
                  pos_d = pos_q - C_ONE;
                  dir_d = 1'b1;
                  sv_d  = 1'b1;
                  idx_d = w_idx;
               end else if (w_delta != 3'd0) begin
                  state_d = ST_FAULT;
               end
            end
         end
         ST_FAULT: begin
            if (clr_err)
               state_d = ST_ACQUIRE;
         end
         default: state_d = ST_ACQUIRE;
      endcase
      if (clr_pos)
         pos_d = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_ACQUIRE;
         pos_q   <= '0;
         idx_q   <= 3'd0;
         dir_q   <= 1'b0;
         sv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         pos_q   <= pos_d;
         idx_q   <= idx_d;
         dir_q   <= dir_d;
         sv_q    <= sv_d;
      end
   end

   assign pos        = pos_q;
   assign idx        = idx_q;
   assign dir        = dir_q;
   assign step_valid = sv_q;
   assign locked     = (state_q == ST_TRACK);
   assign err        = (state_q == ST_FAULT);

endmodule

`default_nettype wire

// File: tb/tb_gray_seq_decoder.sv
// ============================================================================
// tb_gray_seq_decoder : directed stimulus with step scoreboard
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_gray_seq_decoder;

   logic              clk = 1'b0;
   logic              rst, clr_pos, clr_err;
   logic [2:0]        gray_in;
   logic signed [7:0] pos;
   logic [2:0]        idx;
   logic              dir, step_valid, locked, err;

   gray_seq_decoder #(.POS_W(8), .STABLE_CYC(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .gray_in    (gray_in),
      .clr_pos    (clr_pos),
      .clr_err    (clr_err),
      .pos        (pos),
      .idx        (idx),
      .dir        (dir),
      .step_valid (step_valid),
      .locked     (locked),
      .err        (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic [7:0] pos;
      logic       dir;
      logic [2:0] idx;
   } exp_t;

   exp_t       sb[$];
   int         cyc = 0;
   int         errors = 0;
   int         checks = 0;
   logic [7:0] exp_pos = 8'd0;

   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks = checks + 1;
      if (act != exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Expected step lands four edges after the input change at the current negedge
   task automatic push_step(input logic [2:0] new_idx, input logic rev, input logic cleared);
      exp_t e;
      exp_pos = rev ? exp_pos - 8'd1 : exp_pos + 8'd1;
      if (cleared) exp_pos = 8'd0;
      e.cyc = cyc + 4;
      e.pos = exp_pos;
      e.dir = rev;
      e.idx = new_idx;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      if (step_valid) begin
         if (sb.size() == 0) begin
            chk("unexpected_step", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("step_cycle", cyc, e.cyc);
            chk("step_pos", int'(pos), int'($signed(e.pos)));
            chk("step_dir", int'(dir), int'(e.dir));
            chk("step_idx", int'(idx), int'(e.idx));
         end
      end
   end

   logic [2:0] fwd [8];
   logic [2:0] tail [5];

   initial begin
      fwd  = '{3'b100, 3'b110, 3'b111, 3'b101, 3'b001, 3'b011, 3'b010, 3'b000};
      tail = '{3'b101, 3'b001, 3'b011, 3'b010, 3'b000};
      rst = 1'b1; gray_in = 3'b000; clr_pos = 1'b0; clr_err = 1'b0;
      tick(3);
      chk("rst_pos", int'(pos), 0);
      chk("rst_idx", int'(idx), 0);
      chk("rst_dir", int'(dir), 0);
      chk("rst_locked", int'(locked), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_step", int'(step_valid), 0);
      rst = 1'b0;
      tick(4);
      chk("acq_locked", int'(locked), 1);
      chk("acq_idx", int'(idx), 0);
      chk("acq_pos", int'(pos), 0);

      for (int i = 0; i < 8; i++) begin
         gray_in = fwd[i];
         push_step(3'((i + 1) % 8), 1'b0, 1'b0);
         tick(6);
      end
      chk("fwd_pos", int'(pos), 8);
      chk("fwd_idx", int'(idx), 0);
      chk("fwd_dir", int'(dir), 0);

      clr_pos = 1'b1; tick(1); clr_pos = 1'b0; exp_pos = 8'd0;
      tick(1);
      chk("clr_pos", int'(pos), 0);

      gray_in = 3'b010;
      push_step(3'd7, 1'b1, 1'b0);
      tick(6);
      chk("rev_pos", int'(pos), -1);
      chk("rev_idx", int'(idx), 7);
      chk("rev_dir", int'(dir), 1);

      gray_in = 3'b000;
      push_step(3'd0, 1'b0, 1'b0);
      tick(6);

      gray_in = 3'b100; tick(1); gray_in = 3'b000;
      tick(8);
      chk("glitch_pos", int'(pos), 0);
      chk("glitch_idx", int'(idx), 0);

      gray_in = 3'b111;
      tick(6);
      chk("jump_err", int'(err), 1);
      chk("jump_locked", int'(locked), 0);
      chk("jump_pos", int'(pos), 0);
      chk("jump_idx", int'(idx), 0);
      gray_in = 3'b000; tick(6);
      chk("fault_ignore_idx", int'(idx), 0);
      gray_in = 3'b111; tick(6);

      clr_err = 1'b1; tick(1); clr_err = 1'b0;
      chk("clrerr_err", int'(err), 0);
      chk("clrerr_locked", int'(locked), 0);
      tick(2);
      chk("reacq_locked", int'(locked), 1);
      chk("reacq_idx", int'(idx), 3);
      clr_err = 1'b1; tick(1); clr_err = 1'b0; tick(1);
      chk("clrerr_track", int'(locked), 1);

      for (int i = 0; i < 5; i++) begin
         gray_in = tail[i];
         push_step(3'((i + 4) % 8), 1'b0, 1'b0);
         tick(6);
      end
      chk("walk_pos", int'(pos), 5);

      rst = 1'b1; tick(1);
      chk("midrst_pos", int'(pos), 0);
      chk("midrst_locked", int'(locked), 0);
      chk("midrst_idx", int'(idx), 0);
      rst = 1'b0; exp_pos = 8'd0;
      tick(4);
      chk("rst_reacq_locked", int'(locked), 1);

      gray_in = 3'b100;
      push_step(3'd1, 1'b0, 1'b1);
      tick(3);
      clr_pos = 1'b1; tick(1); clr_pos = 1'b0;
      chk("clrstep_pos", int'(pos), 0);
      chk("clrstep_idx", int'(idx), 1);
      chk("clrstep_dir", int'(dir), 0);
      tick(6);
      chk("queue_empty", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
